// File: rtl/q_calc_pkg.sv
// Shared widths, saturation helpers and limits for the pipelined Q calculator.
// Stage payload structs are declared in q_calc_pipe because their widths follow its WIDTH/TAG_W.
package q_calc_pkg;

  localparam int MAX_WIDTH = 32;
  localparam int MAX_RW    = 2 * MAX_WIDTH + 5;

  function automatic int diffW(input int w);
    return w + 1;
  endfunction

  function automatic int tW(input int w);
    return w + 3;
  endfunction

  function automatic int d4W(input int w);
    return w + 2;
  endfunction

  function automatic int prodW(input int w);
    return 2 * w + 4;
  endfunction

  function automatic int resW(input int w);
    return 2 * w + 5;
  endfunction

  function automatic logic signed [MAX_RW-1:0] maxVal(input int w);
    return (MAX_RW'(1) <<< (w - 1)) - MAX_RW'(1);
  endfunction

  // The lower limit of a w-bit signed range is the bitwise complement of its upper limit.
  function automatic logic fits(input logic signed [MAX_RW-1:0] r, input int w);
    return (r <= maxVal(w)) && (r >= ~maxVal(w));
  endfunction

  function automatic logic signed [MAX_RW-1:0] saturate(input logic signed [MAX_RW-1:0] r,
                                                        input int w);
    if (r > maxVal(w))
      return maxVal(w);
    else if (r < ~maxVal(w))
      return ~maxVal(w);
    else
      return r;
  endfunction

endpackage

// File: rtl/q_calc_pipe_reg.sv
// One-entry valid/ready pipeline register; loads when empty or when its content leaves.
module q_calc_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         upValid_i,
  output logic         upReady_o,
  input  logic [W-1:0] upData_i,
  output logic         dnValid_o,
  input  logic         dnReady_i,
  output logic [W-1:0] dnData_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign upReady_o = !valid_q || dnReady_i;
  assign dnValid_o = valid_q;
  assign dnData_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (upReady_o) begin
      valid_d = upValid_i;
      if (upValid_i)
        data_d = upData_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/q_calc_pipe.sv
// Three-stage pipelined Q = ((a - b)*(3c + 1) - 4d) >>> 1 with valid/ready on both sides,
// optional saturation, overflow flag, tag passthrough and a sticky overflow counter.
module q_calc_pipe
  import q_calc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4,
  parameter int SAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH-1:0] c,
  input  logic signed [WIDTH-1:0] d,
  input  logic        [TAG_W-1:0] tag_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic signed [WIDTH-1:0] q,
  output logic                    ovf,
  output logic        [TAG_W-1:0] tag_out,
  output logic        [CNT_W-1:0] ovf_cnt
);

  localparam int DW  = diffW(WIDTH);
  localparam int TW  = tW(WIDTH);
  localparam int D4W = d4W(WIDTH);
  localparam int PW  = prodW(WIDTH);
  localparam int RW  = resW(WIDTH);

  typedef struct packed {
    logic signed [DW-1:0]  diff;
    logic signed [TW-1:0]  t;
    logic signed [D4W-1:0] d4;
    logic [TAG_W-1:0]      tag;
  } s1_t;

  typedef struct packed {
    logic signed [PW-1:0]  prod;
    logic signed [D4W-1:0] d4;
    logic [TAG_W-1:0]      tag;
  } s2_t;

  typedef struct packed {
    logic signed [WIDTH-1:0] q;
    logic                    ovf;
    logic [TAG_W-1:0]        tag;
  } s3_t;

  s1_t s1In, s1Out;
  s2_t s2In, s2Out;
  s3_t s3In, s3Out;
  logic v1, v2;
  logic s2Ready, s3Ready;
  logic signed [RW-1:0] rFull;
  logic [CNT_W-1:0] ovfCnt_q, ovfCnt_d;

  // All arithmetic is done at full precision; only the final stage narrows to WIDTH.
  always_comb begin
    s1In      = '0;
    s1In.diff = DW'(a) - DW'(b);
    s1In.t    = (TW'(c) <<< 1) + TW'(c) + TW'(1);
    s1In.d4   = D4W'(d) <<< 2;
    s1In.tag  = tag_in;

    s2In      = '0;
    s2In.prod = PW'(s1Out.diff) * PW'(s1Out.t);
    s2In.d4   = s1Out.d4;
    s2In.tag  = s1Out.tag;

    rFull     = (RW'(s2Out.prod) - RW'(s2Out.d4)) >>> 1;
    s3In      = '0;
    s3In.ovf  = !fits(MAX_RW'(rFull), WIDTH);
    s3In.q    = (SAT != 0) ? WIDTH'(saturate(MAX_RW'(rFull), WIDTH)) : rFull[WIDTH-1:0];
    s3In.tag  = s2Out.tag;
  end

  q_calc_pipe_reg #(.W($bits(s1_t))) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .upValid_i (valid_in),
    .upReady_o (ready_in),
    .upData_i  (s1In),
    .dnValid_o (v1),
    .dnReady_i (s2Ready),
    .dnData_o  (s1Out)
  );

  q_calc_pipe_reg #(.W($bits(s2_t))) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .upValid_i (v1),
    .upReady_o (s2Ready),
    .upData_i  (s2In),
    .dnValid_o (v2),
    .dnReady_i (s3Ready),
    .dnData_o  (s2Out)
  );

  q_calc_pipe_reg #(.W($bits(s3_t))) u_s3 (
    .clk       (clk),
    .rst       (rst),
    .upValid_i (v2),
    .upReady_o (s3Ready),
    .upData_i  (s3In),
    .dnValid_o (valid_out),
    .dnReady_i (ready_out),
    .dnData_o  (s3Out)
  );

  assign q       = s3Out.q;
  assign ovf     = s3Out.ovf;
  assign tag_out = s3Out.tag;
  assign ovf_cnt = ovfCnt_q;

  // Counts overflowed results only when the consumer takes them, sticking at all-ones.
  always_comb begin
    ovfCnt_d = ovfCnt_q;
    if (valid_out && ready_out && ovf && (ovfCnt_q != '1))
      ovfCnt_d = ovfCnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovfCnt_q <= '0;
    else
      ovfCnt_q <= ovfCnt_d;
  end

endmodule

// File: tb/tb_q_calc_pipe.sv
// Directed-vector and scoreboard bench for q_calc_pipe; a saturating and a wrapping instance share stimulus.
module tb_q_calc_pipe;

  typedef struct { logic signed [15:0] a, b, c, d; logic [3:0] tag; } op_t;
  typedef struct { logic signed [15:0] qs, qw; logic ovf; logic [3:0] tag; } exp_t;
  typedef struct { op_t op; logic signed [15:0] qs, qw; logic ovf; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid_in = 1'b0;
  logic ready_out = 1'b0;
  op_t  curOp;
  logic signed [15:0] a, b, c, d;
  logic [3:0] tag_in;

  logic ready_in0, valid_out0, ovf0;
  logic signed [15:0] q0;
  logic [3:0] tag_out0;
  logic [15:0] ovf_cnt0;
  logic ready_in1, valid_out1, ovf1;
  logic signed [15:0] q1;
  logic [3:0] tag_out1;
  logic [1:0] ovf_cnt1;

  int checks = 0, errors = 0;
  exp_t sb[$];
  int modelOvf = 0, outCount = 0, acceptCount = 0, dirOvf = 0;
  vec_t vecs[8];

  always #5 clk = ~clk;

  assign a = curOp.a;
  assign b = curOp.b;
  assign c = curOp.c;
  assign d = curOp.d;
  assign tag_in = curOp.tag;

  q_calc_pipe #(.WIDTH(16), .TAG_W(4), .SAT(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in0),
    .a(a), .b(b), .c(c), .d(d), .tag_in(tag_in),
    .valid_out(valid_out0), .ready_out(ready_out), .q(q0), .ovf(ovf0),
    .tag_out(tag_out0), .ovf_cnt(ovf_cnt0)
  );

  q_calc_pipe #(.WIDTH(16), .TAG_W(4), .SAT(0), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in1),
    .a(a), .b(b), .c(c), .d(d), .tag_in(tag_in),
    .valid_out(valid_out1), .ready_out(ready_out), .q(q1), .ovf(ovf1),
    .tag_out(tag_out1), .ovf_cnt(ovf_cnt1)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input op_t o);
    exp_t e;
    longint r;
    r = ((longint'(o.a) - longint'(o.b)) * (3 * longint'(o.c) + 1) - 4 * longint'(o.d)) >>> 1;
    e.ovf = (r > 32767) || (r < -32768);
    e.qw  = r[15:0];
    e.qs  = (r > 32767) ? 16'h7FFF : (r < -32768) ? 16'h8000 : r[15:0];
    e.tag = o.tag;
    return e;
  endfunction

  function automatic op_t randOp();
    op_t o;
    if ($urandom_range(0, 1) == 1) begin
      o.a = 16'($urandom);
      o.b = 16'($urandom);
      o.c = 16'($urandom);
      o.d = 16'($urandom);
    end else begin
      o.a = 16'(int'($urandom_range(0, 400)) - 200);
      o.b = 16'(int'($urandom_range(0, 400)) - 200);
      o.c = 16'(int'($urandom_range(0, 60)) - 30);
      o.d = 16'(int'($urandom_range(0, 2000)) - 1000);
    end
    o.tag = 4'($urandom);
    return o;
  endfunction

  function automatic vec_t mkVec(input int va, vb, vc, vd, vt, qs, qw, vo);
    vec_t v;
    v.op.a = 16'(va);
    v.op.b = 16'(vb);
    v.op.c = 16'(vc);
    v.op.d = 16'(vd);
    v.op.tag = 4'(vt);
    v.qs = 16'(qs);
    v.qw = 16'(qw);
    v.ovf = (vo != 0);
    return v;
  endfunction

  // Scoreboard: predicts every accepted op and checks every consumed result in order.
  initial begin
    exp_t e;
    logic prevStall;
    logic signed [15:0] pq;
    logic po;
    logic [3:0] pt;
    prevStall = 1'b0;
    pq = '0;
    po = 1'b0;
    pt = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        modelOvf = 0;
        prevStall = 1'b0;
      end else begin
        if (prevStall)
          check("stall_hold", {valid_out0, q0, ovf0, tag_out0}, {1'b1, pq, po, pt});
        if (valid_out0 && ready_out) begin
          outCount++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_out: got q=%0d tag=%0d, expected no result", q0, tag_out0);
          end else begin
            e = sb.pop_front();
            check("sb_q_sat", q0, e.qs);
            check("sb_ovf", ovf0, e.ovf);
            check("sb_tag", tag_out0, e.tag);
            check("sb_wrap_inst", {valid_out1, q1, ovf1, tag_out1}, {1'b1, e.qw, e.ovf, e.tag});
            if (e.ovf) modelOvf++;
          end
        end
        if (valid_in && ready_in0) begin
          sb.push_back(model(curOp));
          acceptCount++;
        end
        prevStall = valid_out0 && !ready_out;
        pq = q0;
        po = ovf0;
        pt = tag_out0;
      end
    end
  end

  task automatic applyStimulus(input op_t o);
    int n = 0;
    curOp = o;
    valid_in = 1'b1;
    @(negedge clk);
    while (!ready_in0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", (n < 50) ? 1 : 0, 1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    curOp = randOp();
  endtask

  task automatic checkOutput(input vec_t v);
    int n = 0;
    while (!valid_out0 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, 2);
    check("q_sat", q0, v.qs);
    check("q_wrap", q1, v.qw);
    check("ovf", ovf0, v.ovf);
    check("tag", tag_out0, v.op.tag);
    if (v.ovf) dirOvf++;
    @(posedge clk);
    #1;
    check("valid_after", valid_out0, 0);
    check("ovf_cnt", ovf_cnt0, dirOvf);
    check("ovf_cnt_w2", ovf_cnt1, (dirOvf > 3) ? 3 : dirOvf);
  endtask

  task automatic drain(input int limit);
    for (int k = 0; k < limit && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic backpressure();
    op_t ops[20];
    int idx = 0, cyc = 0, leak = 0, outStart;
    logic acc;
    for (int i = 0; i < 20; i++) ops[i] = randOp();
    outStart = outCount;
    valid_in = 1'b1;
    while (idx < 20 && cyc < 200) begin
      ready_out = !(cyc >= 2 && cyc <= 8);
      curOp = ops[idx];
      @(negedge clk);
      if (cyc == 3) begin
        check("bp_ready_drop", ready_in0, 0);
        check("bp_accepts_before_drop", idx, 3);
      end
      if (cyc > 3 && cyc <= 8 && (ready_in0 || ready_in1)) leak++;
      if (cyc == 9) check("bp_drain_fill", {ready_in0, ready_in1}, 3);
      acc = ready_in0;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    valid_in = 1'b0;
    ready_out = 1'b1;
    drain(40);
    check("bp_all_sent", idx, 20);
    check("bp_leak", leak, 0);
    check("bp_drained", sb.size(), 0);
    check("bp_out_count", outCount - outStart, 20);
  endtask

  task automatic randomPhase();
    int cyc = 0, outStart, accStart;
    outStart = outCount;
    accStart = acceptCount;
    while (acceptCount - accStart < 1000 && cyc < 20000) begin
      valid_in  = ($urandom_range(0, 3) != 0);
      ready_out = ($urandom_range(0, 3) != 0);
      curOp = randOp();
      @(posedge clk);
      #1;
      cyc++;
    end
    valid_in = 1'b0;
    ready_out = 1'b1;
    drain(40);
    check("rand_accepts", acceptCount - accStart, 1000);
    check("rand_outputs", outCount - outStart, 1000);
    check("rand_drained", sb.size(), 0);
    check("rand_ovf_cnt", ovf_cnt0, (modelOvf > 65535) ? 65535 : modelOvf);
    check("rand_ovf_cnt_w2", ovf_cnt1, (modelOvf > 3) ? 3 : modelOvf);
  endtask

  task automatic midReset();
    ready_out = 1'b0;
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      curOp = (i == 0) ? vecs[2].op : (i == 1) ? vecs[5].op : vecs[6].op;
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    check("rst_inflight_valid", valid_out0, 1);
    check("rst_inflight_q", q0, 32767);
    #2 rst = 1'b1;
    #1;
    check("rst_valid_out", {valid_out0, valid_out1}, 0);
    check("rst_q", q0, 0);
    check("rst_ovf", {ovf0, ovf1}, 0);
    check("rst_tag", tag_out0, 0);
    check("rst_ovf_cnt", ovf_cnt0, 0);
    check("rst_ovf_cnt_w2", ovf_cnt1, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_out = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready_in", ready_in0, 1);
    check("rst_no_stale", valid_out0, 0);
    dirOvf = 0;
    applyStimulus(vecs[0].op);
    checkOutput(vecs[0]);
  endtask

  initial begin
    vecs[0] = mkVec(-74, -34, 20, 58, 5, -1336, -1336, 0);
    vecs[1] = mkVec(1, 0, 0, 1, 3, -2, -2, 0);
    vecs[2] = mkVec(300, 0, 100, 0, 9, 32767, -20386, 1);
    vecs[3] = mkVec(0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4] = mkVec(10, 3, -1, 2, 12, -11, -11, 0);
    vecs[5] = mkVec(-32768, 32767, -32768, -32768, 15, 32767, -16384, 1);
    vecs[6] = mkVec(-300, 0, 100, 0, 6, -32768, 20386, 1);
    vecs[7] = mkVec(5, 7, 2, -3, 10, -1, -1, 0);

    curOp = randOp();
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid_out", valid_out0, 0);
    check("reset_q", q0, 0);
    check("reset_ovf", ovf0, 0);
    check("reset_tag", tag_out0, 0);
    check("reset_ovf_cnt", ovf_cnt0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_ready_in", ready_in0, 1);

    $display("[TB] directed vectors");
    ready_out = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].op);
      checkOutput(vecs[i]);
    end

    $display("[TB] backpressure stream");
    backpressure();

    $display("[TB] random handshake");
    randomPhase();

    $display("[TB] reset mid-stream");
    midReset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
